booth_mac_accumulator: RTL and testbench

- Sits directly downstream of booth_multiplier_32bit_pipeline and consumes its 64-bit signed product stream.
- Carries valid/last tags alongside the untagged multiplier pipeline, accumulates products into dot-product sums, and buffers finished sums in a small output FIFO.
- Issue side uses in_valid/in_ready. Result side uses out_valid/out_ready.
- Applies credit-based backpressure, because the multiplier pipeline cannot stall.

---
 rtl/booth_mac_accumulator.sv | 143 ++++++++++++++
 tb/tb_booth_mac_accumulator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_mac_accumulator.sv
// Accumulates tagged multiplier products into per-frame dot-product sums; results queue in a small FIFO.
// Latency: accepted last term to out_valid is MUL_LAT+1 cycles; credit-gated issue because the multiplier cannot stall.
module booth_mac_accumulator #(
  parameter int MUL_LAT = 2,
  parameter int ACC_W   = 72,
  parameter int DEPTH   = 2,
  parameter int SAT     = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [63:0]      product_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int CRD_W = $clog2(DEPTH + MUL_LAT + 2) + 1;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } entry_t;

  logic [MUL_LAT-1:0] tag_vld;
  logic [MUL_LAT-1:0] tag_last;
  logic               accept;
  logic               a_valid;
  logic               a_last;
  logic [CRD_W-1:0]   inflight;
  logic [CRD_W-1:0]   credit_need;

  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;
  logic               first;
  logic [ACC_W:0]     base_ext;
  logic [ACC_W:0]     prod_ext;
  logic [ACC_W:0]     sum_ext;
  logic               ovf_now;
  logic [ACC_W-1:0]   sum_res;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               ovf_nxt;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   occupancy;
  logic               push;
  logic               pop;

  assign accept  = in_valid && in_ready;
  assign a_valid = tag_vld[MUL_LAT-1];
  assign a_last  = tag_last[MUL_LAT-1];

  // Tags ride alongside the untagged multiplier so each product meets its valid/last.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld  <= '0;
      tag_last <= '0;
    end else begin
      tag_vld[0]  <= accept;
      tag_last[0] <= accept && in_last;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_last[i] <= tag_last[i-1];
      end
    end
  end

  // Every last in flight has a FIFO slot reserved; non-last terms never need one.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MUL_LAT; i++) begin
      inflight = inflight + {{(CRD_W-1){1'b0}}, tag_last[i]};
    end
    credit_need = CRD_W'(occupancy) + inflight + {{(CRD_W-1){1'b0}}, in_last};
    in_ready    = (credit_need <= CRD_W'(DEPTH));
  end

  always_comb begin
    base_ext = first ? '0 : {acc[ACC_W-1], acc};
    prod_ext = {{(ACC_W-63){product_i[63]}}, product_i};
    sum_ext  = base_ext + prod_ext;
    ovf_now  = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    sum_res  = sum_ext[ACC_W-1:0];
    if ((SAT != 0) && ovf_now) begin
      sum_res = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    cnt_nxt = first ? {{(CNT_W-1){1'b0}}, 1'b1} : cnt + 1'b1;
    ovf_nxt = (first ? 1'b0 : ovf) | ovf_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      first <= 1'b1;
    end else if (a_valid) begin
      acc   <= sum_res;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
      first <= a_last;
    end
  end

  assign push = a_valid && a_last;
  assign pop  = out_valid && out_ready;

  // Push at full with a pop overwrites the departing head slot, which is safe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {sum_res, cnt_nxt, ovf_nxt};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occupancy <= occupancy + 1'b1;
      else if (pop && !push) occupancy <= occupancy - 1'b1;
    end
  end

  assign out_valid = (occupancy != '0);
  assign out_data  = mem[rd_ptr].data;
  assign out_count = mem[rd_ptr].count;
  assign out_ovf   = mem[rd_ptr].ovf;

  a_no_overfill: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (occupancy == OCC_W'(DEPTH))));
endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Drives two accumulator configurations (72-bit wrap, 64-bit saturate) from one stream and scores them against a frame-level model.
module tb_booth_mac_accumulator;
  localparam int ML    = 2;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] product_i = '0;

  logic        rdy0, vld0, ovf0;
  logic [71:0] dat0;
  logic [15:0] cnt0;
  logic        rdy1, vld1, ovf1;
  logic [63:0] dat1;
  logic [15:0] cnt1;

  booth_mac_accumulator #(.MUL_LAT(ML), .ACC_W(72), .DEPTH(DEPTH), .SAT(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy0),
    .product_i(product_i), .out_valid(vld0), .out_ready(out_ready),
    .out_data(dat0), .out_count(cnt0), .out_ovf(ovf0));

  booth_mac_accumulator #(.MUL_LAT(ML), .ACC_W(64), .DEPTH(DEPTH), .SAT(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy1),
    .product_i(product_i), .out_valid(vld1), .out_ready(out_ready),
    .out_data(dat1), .out_count(cnt1), .out_ovf(ovf1));

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d0;
    logic [127:0] d1;
    int           cnt;
    bit           o0;
    bit           o1;
    int           rdy;
  } exp_t;

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     outstanding = 0;
  longint terms[$];
  exp_t   q[$];
  longint mp [ML];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference frame sum: exact running total, range-checked against a w-bit signed accumulator.
  function automatic void frame_eval(input int w, input bit sat, output logic [127:0] res, output bit ovf);
    logic signed [127:0] acc, mx, mn, t;
    logic [127:0] mask;
    mask = (128'd1 << w) - 128'd1;
    mx   = (128'sd1 <<< (w - 1)) - 128'sd1;
    mn   = -(128'sd1 <<< (w - 1));
    acc  = '0;
    ovf  = 1'b0;
    foreach (terms[i]) begin
      t   = terms[i];
      acc = acc + t;
      if (acc > mx || acc < mn) begin
        ovf = 1'b1;
        if (sat) acc = (acc > mx) ? mx : mn;
        else begin
          acc = acc & mask;
          if (acc[w-1]) acc = acc - (128'sd1 <<< w);
        end
      end
    end
    res = acc & mask;
  endfunction

  task automatic step(input bit v, input bit l, input int a, input int b, input bit ordy,
                      input bit r, output bit took);
    bit   exp_rdy, ev;
    exp_t e;
    took      = 1'b0;
    rst       = r;
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
    product_i = mp[ML-1];
    for (int i = ML - 1; i > 0; i--) mp[i] = mp[i-1];
    mp[0] = longint'(a) * longint'(b);
    #1;
    if (r) begin
      q.delete();
      terms.delete();
      outstanding = 0;
    end else begin
      exp_rdy = (outstanding + int'(l)) <= DEPTH;
      check("u0.in_ready", 128'(rdy0), 128'(exp_rdy));
      check("u1.in_ready", 128'(rdy1), 128'(exp_rdy));
      ev = (q.size() > 0) && (q[0].rdy <= cyc);
      check("u0.out_valid", 128'(vld0), 128'(ev));
      check("u1.out_valid", 128'(vld1), 128'(ev));
      if (ev) begin
        check("u0.out_data", 128'(dat0), q[0].d0);
        check("u0.out_count", 128'(cnt0), 128'(q[0].cnt));
        check("u0.out_ovf", 128'(ovf0), 128'(q[0].o0));
        check("u1.out_data", 128'(dat1), q[0].d1);
        check("u1.out_count", 128'(cnt1), 128'(q[0].cnt));
        check("u1.out_ovf", 128'(ovf1), 128'(q[0].o1));
        if (ordy) begin
          void'(q.pop_front());
          outstanding--;
        end
      end
      if (v && exp_rdy) begin
        took = 1'b1;
        terms.push_back(longint'(a) * longint'(b));
        if (l) begin
          frame_eval(72, 1'b0, e.d0, e.o0);
          frame_eval(64, 1'b1, e.d1, e.o1);
          e.cnt = terms.size() & 16'hFFFF;
          e.rdy = cyc + ML + 1;
          q.push_back(e);
          outstanding++;
          terms.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit ordy);
    bit tk;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, ordy, 1'b0, tk);
  endtask

  initial begin
    bit tk;
    int a, b;
    bit v, l, o, r;
    for (int i = 0; i < ML; i++) mp[i] = 0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, tk);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, tk);
    check("rst.out_valid", 128'(vld0), 128'd0);
    check("rst.out_data", 128'(dat0), 128'd0);
    check("rst.out_count", 128'(cnt0), 128'd0);
    check("rst.out_ovf", 128'(ovf0), 128'd0);

    // Three-term frame, latency MUL_LAT+1.
    step(1'b1, 1'b0, 10, 20, 1'b1, 1'b0, tk);
    step(1'b1, 1'b0, 1, 20, 1'b1, 1'b0, tk);
    step(1'b1, 1'b1, -15, 30, 1'b1, 1'b0, tk);
    idle(5, 1'b1);

    // Back-to-back single-term frames at the 32-bit extremes.
    step(1'b1, 1'b1, 32'h8000_0000, -1, 1'b1, 1'b0, tk);
    step(1'b1, 1'b1, 32'h7FFF_FFFF, -1, 1'b1, 1'b0, tk);
    idle(5, 1'b1);

    // Credit exhaustion with a stalled consumer; non-last term still accepted.
    step(1'b1, 1'b1, 1, 1, 1'b0, 1'b0, tk);
    step(1'b1, 1'b1, 2, 1, 1'b0, 1'b0, tk);
    step(1'b1, 1'b1, 3, 1, 1'b0, 1'b0, tk);
    step(1'b1, 1'b0, 5, 0, 1'b0, 1'b0, tk);
    idle(4, 1'b0);
    tk = 1'b0;
    for (int t = 0; t < 10 && !tk; t++) step(1'b1, 1'b1, 3, 1, 1'b1, 1'b0, tk);
    idle(6, 1'b1);

    // Push and pop coincide on the edge the aligned last arrives.
    step(1'b1, 1'b1, 6, 1, 1'b0, 1'b0, tk);
    idle(4, 1'b0);
    step(1'b1, 1'b1, 7, 1, 1'b0, 1'b0, tk);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, tk);
    idle(5, 1'b1);

    // Saturation in the 64-bit instance, then a clean frame.
    step(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, tk);
    step(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, tk);
    step(1'b1, 1'b1, 5, 1, 1'b1, 1'b0, tk);
    idle(6, 1'b1);

    // Reset in the middle of a frame discards the partial sum.
    step(1'b1, 1'b0, 9, 9, 1'b1, 1'b0, tk);
    step(1'b1, 1'b0, 9, 9, 1'b1, 1'b0, tk);
    step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1, tk);
    step(1'b1, 1'b1, 7, 3, 1'b1, 1'b0, tk);
    idle(6, 1'b1);

    for (int k = 0; k < 2500; k++) begin
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 3) == 0);
      o = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        b = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        a = $urandom;
        b = $urandom;
      end
      step(v, l, a, b, o, r, tk);
    end
    idle(10, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
